// File: rtl/fetch_stage_unit.sv
// IF stage of the 5-stage RV32I pipeline: PC register, next-PC prediction and IF/ID register.
// Optional macro BTB_PREDICT_EN adds a direct-mapped BTB with 2-bit counters; default is PC+4.
module fetch_stage_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        is_halted,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_is_ctrl,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pred_pc,
  output logic        IF_ID_valid
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pred_pc;
  logic        halting;

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;

  // A redirect outranks halting, so the edge that raises is_halted alongside a redirect stays in RUN.
  always_comb begin
    state_d = state_q;
    halting = 1'b0;
    if (!ex_redirect) begin
      halting = (state_q == ST_HALT) || is_halted;
      if (is_halted) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      IF_ID_inst    <= NOP_INST;
      IF_ID_pc      <= 32'd0;
      IF_ID_pred_pc <= 32'd0;
      IF_ID_valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ex_redirect) begin
        pc_q        <= ex_redirect_pc;
        IF_ID_inst  <= NOP_INST;
        IF_ID_valid <= 1'b0;
      end else if (halting) begin
        IF_ID_inst  <= NOP_INST;
        IF_ID_valid <= 1'b0;
      end else begin
        if (PC_write) pc_q <= pred_pc;
        if (IF_ID_write) begin
          IF_ID_inst    <= imem_rdata;
          IF_ID_pc      <= pc_q;
          IF_ID_pred_pc <= pred_pc;
          IF_ID_valid   <= 1'b1;
        end
      end
    end
  end

`ifdef BTB_PREDICT_EN
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             unused_btb;

  assign rd_idx     = pc_q[IDX+1:2];
  assign rd_tag     = pc_q[31:IDX+2];
  assign wr_idx     = ex_pc[IDX+1:2];
  assign wr_tag     = ex_pc[31:IDX+2];
  assign rd_hit     = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign wr_hit     = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign pred_pc    = (rd_hit && btb_ctr[rd_idx][1]) ? btb_target[rd_idx] : pc_plus4;
  assign unused_btb = ^ex_pc[1:0];

  // Training ignores stalls; the lookup above reads the array before this edge writes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b01;
      end
    end else if (ex_is_ctrl) begin
      if (wr_hit) begin
        if (ex_taken) begin
          btb_target[wr_idx] <= ex_target;
          if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'b01;
        end else if (btb_ctr[wr_idx] != 2'b00) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'b01;
        end
      end else begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= ex_target;
        btb_ctr[wr_idx]    <= ex_taken ? 2'b10 : 2'b01;
      end
    end
  end
`else
  logic unused_btb;

  assign pred_pc    = pc_plus4;
  assign unused_btb = ^{ex_is_ctrl, ex_pc, ex_taken, ex_target, BTB_ENTRIES[0]};
`endif

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Scoreboard bench for fetch_stage_unit: a behavioural model queues expected post-edge state,
// and a monitor compares it with the DUT one step after every rising edge.
module tb_fetch_stage_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_write = 1'b0, IF_ID_write = 1'b0, is_halted = 1'b0;
  logic        ex_redirect = 1'b0, ex_is_ctrl = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_redirect_pc = '0, ex_pc = '0, ex_target = '0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_inst, IF_ID_pc, IF_ID_pred_pc;
  logic        IF_ID_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage_unit #(
    .RESET_PC(32'h0000_0000), .BTB_ENTRIES(16), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .reset(reset), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .is_halted(is_halted), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_is_ctrl(ex_is_ctrl), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .IF_ID_inst(IF_ID_inst),
    .IF_ID_pc(IF_ID_pc), .IF_ID_pred_pc(IF_ID_pred_pc), .IF_ID_valid(IF_ID_valid)
  );

  // Instruction memory contents are a fixed scramble of the address so every word is distinct.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ifpc;
    logic [31:0] ifpred;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_inst, m_ifpc, m_ifpred;
  logic        m_valid, m_halted;

`ifdef BTB_PREDICT_EN
  logic        mb_v   [16];
  logic [31:0] mb_tag [16];
  logic [31:0] mb_tgt [16];
  int          mb_ctr [16];
`endif

  function automatic logic [31:0] model_pred(input logic [31:0] a);
`ifdef BTB_PREDICT_EN
    int i;
    i = int'((a / 4) % 16);
    if (mb_v[i] && mb_tag[i] == a / 64 && mb_ctr[i] >= 2) return mb_tgt[i];
`endif
    return a + 32'd4;
  endfunction

  task automatic model_train(input logic [31:0] epc, input logic tk, input logic [31:0] tgt);
`ifdef BTB_PREDICT_EN
    int i;
    i = int'((epc / 4) % 16);
    if (mb_v[i] && mb_tag[i] == epc / 64) begin
      if (tk) begin
        mb_tgt[i] = tgt;
        mb_ctr[i] = (mb_ctr[i] == 3) ? 3 : mb_ctr[i] + 1;
      end else begin
        mb_ctr[i] = (mb_ctr[i] == 0) ? 0 : mb_ctr[i] - 1;
      end
    end else begin
      mb_v[i]   = 1'b1;
      mb_tag[i] = epc / 64;
      mb_tgt[i] = tgt;
      mb_ctr[i] = tk ? 2 : 1;
    end
`else
    if (tk && epc == tgt) m_pc = m_pc;
`endif
  endtask

  task automatic model_step(input logic rst, input logic pcw, input logic ifw, input logic hlt,
                            input logic rdr, input logic [31:0] rpc, input logic ctl,
                            input logic [31:0] epc, input logic tk, input logic [31:0] tgt);
    logic [31:0] pred;
    exp_t        e;
    if (rst) begin
      m_pc = 32'd0; m_inst = NOP; m_ifpc = 32'd0; m_ifpred = 32'd0;
      m_valid = 1'b0; m_halted = 1'b0;
`ifdef BTB_PREDICT_EN
      for (int i = 0; i < 16; i++) begin mb_v[i] = 1'b0; mb_ctr[i] = 1; end
`endif
    end else begin
      pred = model_pred(m_pc);
      if (ctl) model_train(epc, tk, tgt);
      if (rdr) begin
        m_pc = rpc; m_inst = NOP; m_valid = 1'b0;
      end else if (m_halted || hlt) begin
        m_halted = 1'b1; m_inst = NOP; m_valid = 1'b0;
      end else begin
        if (ifw) begin
          m_inst = imem_word(m_pc); m_ifpc = m_pc; m_ifpred = pred; m_valid = 1'b1;
        end
        if (pcw) m_pc = pred;
      end
    end
    e.pc = m_pc; e.inst = m_inst; e.ifpc = m_ifpc; e.ifpred = m_ifpred; e.valid = m_valid;
    sb.push_back(e);
  endtask

  // Drives one cycle of inputs at the falling edge and queues the state expected after the next rise.
  task automatic applyStimulus(input logic rst, input logic pcw, input logic ifw, input logic hlt,
                               input logic rdr, input logic [31:0] rpc, input logic ctl,
                               input logic [31:0] epc, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; PC_write = pcw; IF_ID_write = ifw; is_halted = hlt;
    ex_redirect = rdr; ex_redirect_pc = rpc; ex_is_ctrl = ctl; ex_pc = epc;
    ex_taken = tk; ex_target = tgt;
    model_step(rst, pcw, ifw, hlt, rdr, rpc, ctl, epc, tk, tgt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] rpc, input logic pcw);
    applyStimulus(1'b0, pcw, pcw, 1'b0, 1'b1, rpc, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic train(input logic [31:0] epc, input logic tk, input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, epc, tk, tgt);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("imem_addr", imem_addr, e.pc);
        checkOutput("IF_ID_inst", IF_ID_inst, e.inst);
        checkOutput("IF_ID_pc", IF_ID_pc, e.ifpc);
        checkOutput("IF_ID_pred_pc", IF_ID_pred_pc, e.ifpred);
        checkOutput("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, e.valid});
      end
    end
  end

  initial begin : stimulus
    logic rst, pcw, ifw, hlt, rdr, ctl, tk;
    logic [31:0] rpc, epc, tgt;

    $display("[TB] reset and sequential fetch");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    run(4);

    $display("[TB] stall and drop");
    redirect(32'h20, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    run(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    run(1);

    $display("[TB] redirect during stall and PC wrap");
    redirect(32'h100, 1'b0);
    run(2);
    redirect(32'hFFFF_FFFC, 1'b1);
    run(3);

    $display("[TB] branch prediction training");
    redirect(32'h0, 1'b1);
    train(32'h10, 1'b1, 32'h80);
    run(5);
    train(32'h10, 1'b0, 32'h80);
    train(32'h10, 1'b0, 32'h80);
    redirect(32'h10, 1'b1);
    run(3);

    $display("[TB] halt and recovery");
    redirect(32'h40, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    run(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    run(3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      hlt = ($urandom_range(0, 79) == 0);
      rdr = ($urandom_range(0, 9) == 0);
      pcw = ($urandom_range(0, 4) != 0);
      ifw = ($urandom_range(0, 4) != 0);
      ctl = ($urandom_range(0, 2) == 0);
      tk  = ($urandom_range(0, 1) == 0);
      rpc = 32'($urandom_range(0, 127)) << 2;
      epc = 32'($urandom_range(0, 127)) << 2;
      tgt = 32'($urandom_range(0, 127)) << 2;
      applyStimulus(rst, pcw, ifw, hlt, rdr, rpc, ctl, epc, tk, tgt);
    end

    @(posedge clk);
    #2;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
